// File: rtl/zip_dbg_sequencer_if.sv
// Host request/response and debug Wishbone signals of the ZipCPU debug sequencer.
// Signal directions are named from the sequencer's point of view.
interface zip_dbg_sequencer_if;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned OW = 3;

  logic          i_req_valid;
  logic          o_req_ready;
  logic [OW-1:0] i_req_op;
  logic [RW-1:0] i_req_reg;
  logic [DW-1:0] i_req_data;
  logic          o_rsp_valid;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic          o_halted;
  logic          o_dbg_cyc;
  logic          o_dbg_stb;
  logic          o_dbg_we;
  logic          o_dbg_addr;
  logic [DW-1:0] o_dbg_data;
  logic          i_dbg_ack;
  logic          i_dbg_stall;
  logic [DW-1:0] i_dbg_data;

  modport master (
    input  i_req_valid, i_req_op, i_req_reg, i_req_data,
    input  i_dbg_ack, i_dbg_stall, i_dbg_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_halted,
    output o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr, o_dbg_data
  );

  modport slave (
    output i_req_valid, i_req_op, i_req_reg, i_req_data,
    output i_dbg_ack, i_dbg_stall, i_dbg_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_halted,
    input  o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr, o_dbg_data
  );
endinterface

// File: rtl/zip_dbg_sequencer.sv
// Expands single host debug requests into the control/data Wishbone sequences
// of the ZipCPU debug port, with a bus timeout and a shadow halted flag.
module zip_dbg_sequencer #(
  parameter bit          START_HALTED = 1'b0,
  parameter int unsigned LGTIMEOUT    = 10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  zip_dbg_sequencer_if.master bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned OW = 3;
  localparam logic [LGTIMEOUT-1:0] TMO_LAST = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

  localparam logic [OW-1:0] OP_RD     = 3'd0;
  localparam logic [OW-1:0] OP_WR     = 3'd1;
  localparam logic [OW-1:0] OP_HALT   = 3'd2;
  localparam logic [OW-1:0] OP_RESUME = 3'd3;
  localparam logic [OW-1:0] OP_STEP   = 3'd4;
  localparam logic [OW-1:0] OP_RESET  = 3'd5;
  localparam logic [OW-1:0] OP_STATUS = 3'd6;
  localparam logic [OW-1:0] OP_RSVD   = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_CTL, S_DAT, S_RST, S_STAT, S_RSP} state_e;

  state_e         state_q, state_d;
  logic [OW-1:0]  op_q, op_d;
  logic [RW-1:0]  reg_q, reg_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           was_halted_q, was_halted_d;
  logic           cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, addr_q, addr_d;
  logic [DW-1:0]  dat_q, dat_d;
  logic [LGTIMEOUT-1:0] tmo_q, tmo_d;
  logic           rdy_q, rdy_d;
  logic           rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d, rd_q, rd_d;
  logic           err_q, err_d, halted_q, halted_d;
  logic           phase_ack, tmo_hit;

  // Control word: [4:0] index, [6] reset, [8] step, [10] halt, [11] clear cache.
  function automatic logic [DW-1:0] ctl_word(input logic [OW-1:0] op, input logic [RW-1:0] idx,
                                             input logic clr, input logic halted);
    logic [DW-1:0] w;
    w = '0;
    case (op)
      OP_RD, OP_WR: begin w[10] = 1'b1; w[4:0] = idx; end
      OP_HALT:      w[10] = 1'b1;
      OP_RESUME:    w[11] = clr;
      OP_STEP:      w[8]  = 1'b1;
      OP_RESET:     begin w[6] = 1'b1; w[10] = halted; end
      default:      w = '0;
    endcase
    return w;
  endfunction

  // Ack counts only once the strobe has been (or is being) accepted.
  assign phase_ack = cyc_q && bus.i_dbg_ack && (!stb_q || !bus.i_dbg_stall);
  assign tmo_hit   = cyc_q && (tmo_q == TMO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      reg_q        <= '0;
      wdata_q      <= '0;
      was_halted_q <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 1'b0;
      dat_q        <= '0;
      tmo_q        <= '0;
      rdy_q        <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      rd_q         <= '0;
      err_q        <= 1'b0;
      halted_q     <= START_HALTED;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      was_halted_q <= was_halted_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      dat_q        <= dat_d;
      tmo_q        <= tmo_d;
      rdy_q        <= rdy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      rd_q         <= rd_d;
      err_q        <= err_d;
      halted_q     <= halted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    reg_d        = reg_q;
    wdata_d      = wdata_q;
    was_halted_d = was_halted_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    addr_d       = addr_q;
    dat_d        = dat_q;
    tmo_d        = tmo_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_data_d   = rsp_data_q;
    rd_d         = rd_q;
    err_d        = err_q;
    halted_d     = halted_q;

    // Handshake bookkeeping common to every active phase.
    if (cyc_q) begin
      tmo_d = tmo_q + LGTIMEOUT'(1);
      if (stb_q && !bus.i_dbg_stall) stb_d = 1'b0;
      if (phase_ack || tmo_hit) begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.i_req_valid && rdy_q) begin
          op_d         = bus.i_req_op;
          reg_d        = bus.i_req_reg;
          wdata_d      = bus.i_req_data;
          was_halted_d = halted_q;
          err_d        = 1'b0;
          if (bus.i_req_op == OP_RSVD) begin
            state_d = S_RSP;
            err_d   = 1'b1;
          end else begin
            // First phase launches straight from the accept cycle.
            state_d = (bus.i_req_op == OP_STATUS) ? S_STAT : S_CTL;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            addr_d  = 1'b0;
            we_d    = (bus.i_req_op != OP_STATUS);
            dat_d   = ctl_word(bus.i_req_op, bus.i_req_reg, bus.i_req_data[11], halted_q);
            tmo_d   = '0;
          end
        end
      end
      S_CTL: begin
        if (phase_ack) begin
          if (op_q == OP_RESUME) halted_d = 1'b0;
          else if (op_q != OP_RESET) halted_d = 1'b1;
          state_d = (op_q == OP_RD || op_q == OP_WR) ? S_DAT : S_RSP;
        end else if (tmo_hit) begin
          state_d = S_RSP;
          err_d   = 1'b1;
        end
      end
      S_DAT: begin
        if (!cyc_q) begin
          cyc_d  = 1'b1;
          stb_d  = 1'b1;
          addr_d = 1'b1;
          we_d   = (op_q == OP_WR);
          dat_d  = wdata_q;
          tmo_d  = '0;
        end else if (phase_ack) begin
          rd_d    = bus.i_dbg_data;
          state_d = was_halted_q ? S_RSP : S_RST;
        end else if (tmo_hit) begin
          state_d = S_RSP;
          err_d   = 1'b1;
        end
      end
      S_RST: begin
        if (!cyc_q) begin
          cyc_d  = 1'b1;
          stb_d  = 1'b1;
          addr_d = 1'b0;
          we_d   = 1'b1;
          dat_d  = DW'(reg_q);
          tmo_d  = '0;
        end else if (phase_ack) begin
          halted_d = 1'b0;
          state_d  = S_RSP;
        end else if (tmo_hit) begin
          state_d = S_RSP;
          err_d   = 1'b1;
        end
      end
      S_STAT: begin
        if (phase_ack) begin
          rd_d    = bus.i_dbg_data;
          state_d = S_RSP;
        end else if (tmo_hit) begin
          state_d = S_RSP;
          err_d   = 1'b1;
        end
      end
      S_RSP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        if (!err_q && (op_q == OP_RD || op_q == OP_STATUS)) rsp_data_d = rd_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready reopens only after the response pulse has gone.
  assign rdy_d = (state_d == S_IDLE) && !rsp_valid_d;

  assign bus.o_req_ready = rdy_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_halted    = halted_q;
  assign bus.o_dbg_cyc   = cyc_q;
  assign bus.o_dbg_stb   = stb_q;
  assign bus.o_dbg_we    = we_q;
  assign bus.o_dbg_addr  = addr_q;
  assign bus.o_dbg_data  = dat_q;
endmodule
